dff_reg_arbiter: RTL
====================

DFF_REG_ARBITER -- requirements
Module: dff_reg_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 C  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 R  input  1  asynchronous active-low reset; 0 SHALL force reset state immediately.
REQ-004 req0, req1  input  1 each  write/command request from requester 0 or 1.
REQ-005 op0, op1  input  2 each  command: 00 load din, 01 clear (Q=0000), 10 preset (Q=1111), 11 no-op (hold).
REQ-006 din0, din1  input  4 each  load data for the matching requester.
REQ-007 gnt0, gnt1  output  1 each  requester currently owns the register.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 Q  output  4  shared register contents (4 D flip-flops with clear/preset).
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-012 IDLE: with no req high, stay IDLE; with any req high at an edge, go to EXEC and latch the winner's id, op and din.
REQ-013 Arbitration SHALL be round-robin with a 1-bit priority pointer: only one req high -> that requester wins; both high -> pointer side wins.
REQ-014 The pointer SHALL switch to the non-winner at the same edge that leaves DONE, so back-to-back contention alternates 0,1,0,1...
REQ-015 EXEC: gnt of the winner SHALL be high for the whole state; at the edge leaving EXEC, Q SHALL take the latched op result; next state DONE.
REQ-016 DONE: gnt stays high, done of the winner SHALL be high for exactly this one cycle; next state IDLE unconditionally.
REQ-017 Latency: req sampled at edge k -> gnt high after edge k, Q updated at edge k+1, done high from k+1 to k+2, IDLE after k+2; one transaction = 3 cycles.
REQ-018 Operands SHALL be taken only from the latched copy; din/op/req changes during EXEC or DONE SHALL have no effect.
REQ-019 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high at any time; gnt SHALL never be high in IDLE.
REQ-020 A req still high in IDLE (the cycle after DONE) SHALL be treated as a new request; requesters drop req on seeing done to avoid a repeat.
REQ-021 op 11 SHALL complete the full handshake with Q unchanged.
REQ-022 Q SHALL change only at the edge leaving EXEC or on reset.

Reset
REQ-023 R=0 SHALL asynchronously set Q=0000, state IDLE, pointer=0, latched id/op/din=0, gnt0=gnt1=done0=done1=busy=0.
REQ-024 Reset during EXEC or DONE SHALL abort the transaction: no done pulse, Q=0000, and no pending request is retained.
REQ-025 After R returns to 1, the first rising edge SHALL sample requests normally.

Verification
REQ-026 Reset: R=0 with req0=1, op0=10 -> Q=0000, gnt/done/busy=0 throughout; release R -> preset to Q=1111 after 2 edges, done0 pulses for 1 cycle.
REQ-027 Single load: req0=1, op0=00, din0=1010 -> gnt0 high 2 cycles, Q=1010 after edge k+1, done0 high 1 cycle, busy low after edge k+2.
REQ-028 Contention: req0=req1=1 held, din0=0011, din1=1100, op=00 -> grants 0,1,0 in consecutive 3-cycle transactions; Q sequence 0011,1100,0011.
REQ-029 Clear/preset/no-op: starting Q=0110, req1 with op1=10, then 01, then 11 -> Q=1111, 0000, 0000; each gives exactly one done1 pulse.
REQ-030 Operand stability: req0 load din0=0101, change din0 to 1111 and op0 to 01 in EXEC -> Q=0101.
REQ-031 Mid-op reset: pull R=0 during EXEC of load 1001 -> Q=0000 immediately, no done pulse, IDLE on release.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
// Two-requester arbiter guarding a shared 4-bit register with load/clear/preset/hold commands.
// Each transaction runs IDLE -> EXEC -> DONE; round-robin pointer resolves simultaneous requests.
module dff_reg_arbiter (
  input  logic       C,
  input  logic       R,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] din0,
  input  logic [3:0] din1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] Q,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpClear  = 2'b01;
  localparam logic [1:0] OpPreset = 2'b10;
  localparam logic [1:0] OpHold   = 2'b11;

  state_e     r_state;
  state_e     w_state_nxt;
  logic       r_ptr;
  logic       r_id;
  logic [1:0] r_op;
  logic [3:0] r_din;
  logic [3:0] r_q;

  logic       w_any_req;
  logic       w_winner;
  logic [1:0] w_win_op;
  logic [3:0] w_win_din;
  logic [3:0] w_result;

  // Arbitration: a lone requester wins outright; on contention the pointer side wins.
  always_comb begin
    w_any_req = req0 | req1;
    w_winner  = (req0 & req1) ? r_ptr : req1;
    w_win_op  = w_winner ? op1 : op0;
    w_win_din = w_winner ? din1 : din0;
  end

  // Next-state logic; DONE always returns to IDLE so a held req is re-sampled one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_nxt = StExec;
      StExec:  w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winner's operands once; later input changes are ignored until the next IDLE.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_id  <= 1'b0;
      r_op  <= 2'b00;
      r_din <= 4'b0000;
    end else if (r_state == StIdle && w_any_req) begin
      r_id  <= w_winner;
      r_op  <= w_win_op;
      r_din <= w_win_din;
    end
  end

  // Hand priority to the other requester as the transaction retires.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_ptr <= 1'b0;
    end else if (r_state == StDone) begin
      r_ptr <= ~r_id;
    end
  end

  // Command decode applied to the latched operands.
  always_comb begin
    w_result = r_q;
    unique case (r_op)
      OpLoad:   w_result = r_din;
      OpClear:  w_result = 4'b0000;
      OpPreset: w_result = 4'b1111;
      OpHold:   w_result = r_q;
      default:  w_result = r_q;
    endcase
  end

  // Shared register: only written on the edge leaving EXEC.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_q <= 4'b0000;
    end else if (r_state == StExec) begin
      r_q <= w_result;
    end
  end

  // Outputs decoded from registered state only, so they are glitch-free and reset cleanly.
  always_comb begin
    busy  = (r_state != StIdle);
    gnt0  = busy && (r_id == 1'b0);
    gnt1  = busy && (r_id == 1'b1);
    done0 = (r_state == StDone) && (r_id == 1'b0);
    done1 = (r_state == StDone) && (r_id == 1'b1);
    Q     = r_q;
  end

endmodule
